axi_mem_responder: RTL and testbench

//  AXI4 slave memory model answering the kernel's m00_axi read and write masters.

---
 rtl/axi_mem_responder.sv | 156 +++++++++++++++
 tb/tb_axi_mem_responder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_responder.sv
// AXI4 slave memory model: independent INCR read and write burst engines over a
// byte-maskable word array. Memory contents survive reset; only the FSMs clear.
module axi_mem_responder #(
  parameter int C_S_AXI_ADDR_WIDTH = 64,
  parameter int C_S_AXI_DATA_WIDTH = 512,
  parameter int C_MEM_DEPTH        = 1024
) (
  input  logic                              ap_clk,
  input  logic                              ap_rst_n,
  input  logic                              s_axi_awvalid,
  output logic                              s_axi_awready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [7:0]                        s_axi_awlen,
  input  logic                              s_axi_wvalid,
  output logic                              s_axi_wready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                              s_axi_wlast,
  output logic                              s_axi_bvalid,
  input  logic                              s_axi_bready,
  input  logic                              s_axi_arvalid,
  output logic                              s_axi_arready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic [7:0]                        s_axi_arlen,
  output logic                              s_axi_rvalid,
  input  logic                              s_axi_rready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
  output logic                              s_axi_rlast,
  output logic                              wlast_err
);
  localparam int BW   = C_S_AXI_DATA_WIDTH / 8;
  localparam int OFFS = $clog2(BW);
  localparam int IW   = $clog2(C_MEM_DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_DATA} rstate_e;

  logic [C_S_AXI_DATA_WIDTH-1:0] mem_q [C_MEM_DEPTH];

  wstate_e                       w_state_q;
  logic [IW-1:0]                 w_idx_q;
  logic [7:0]                    w_cnt_q;
  logic                          awready_q, wready_q, bvalid_q, wlast_err_q;

  rstate_e                       r_state_q;
  logic [IW-1:0]                 r_idx_q, r_idx_d;
  logic [7:0]                    r_cnt_q;
  logic                          arready_q, rvalid_q, rlast_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;

  logic                          w_beat;
  logic [IW-1:0]                 aw_idx, ar_idx;
  logic                          unused_addr;

  // Byte offset bits are dropped and high bits fold onto the array (mod depth).
  assign aw_idx      = s_axi_awaddr[OFFS +: IW];
  assign ar_idx      = s_axi_araddr[OFFS +: IW];
  assign unused_addr = ^{s_axi_awaddr, s_axi_araddr};
  assign w_beat      = wready_q && s_axi_wvalid;

  always_ff @(posedge ap_clk) begin
    if (w_beat) begin
      for (int b = 0; b < BW; b++)
        if (s_axi_wstrb[b]) mem_q[w_idx_q][8*b +: 8] <= s_axi_wdata[8*b +: 8];
    end
  end

  // The beat counter ends the burst; wlast is only cross-checked against it.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      w_state_q   <= W_IDLE;
      w_idx_q     <= '0;
      w_cnt_q     <= '0;
      awready_q   <= 1'b1;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      wlast_err_q <= 1'b0;
    end else begin
      case (w_state_q)
        W_IDLE: if (s_axi_awvalid) begin
          w_idx_q   <= aw_idx;
          w_cnt_q   <= s_axi_awlen;
          awready_q <= 1'b0;
          wready_q  <= 1'b1;
          w_state_q <= W_DATA;
        end
        W_DATA: if (s_axi_wvalid) begin
          w_idx_q <= w_idx_q + IW'(1);
          w_cnt_q <= w_cnt_q - 8'd1;
          if ((w_cnt_q == 8'd0) != s_axi_wlast) wlast_err_q <= 1'b1;
          if (w_cnt_q == 8'd0) begin
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            w_state_q <= W_RESP;
          end
        end
        W_RESP: if (s_axi_bready) begin
          bvalid_q  <= 1'b0;
          awready_q <= 1'b1;
          w_state_q <= W_IDLE;
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  // Word loaded on this edge: the AR start index when idle, else the running index.
  assign r_idx_d = (r_state_q == R_IDLE) ? ar_idx : r_idx_q;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state_q <= R_IDLE;
      r_idx_q   <= '0;
      r_cnt_q   <= '0;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: if (s_axi_arvalid) begin
          rdata_q   <= mem_q[r_idx_d];
          r_idx_q   <= r_idx_d + IW'(1);
          r_cnt_q   <= s_axi_arlen;
          rlast_q   <= (s_axi_arlen == 8'd0);
          rvalid_q  <= 1'b1;
          arready_q <= 1'b0;
          r_state_q <= R_DATA;
        end
        R_DATA: if (s_axi_rready) begin
          if (rlast_q) begin
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            arready_q <= 1'b1;
            r_state_q <= R_IDLE;
          end else begin
            rdata_q <= mem_q[r_idx_d];
            r_idx_q <= r_idx_d + IW'(1);
            r_cnt_q <= r_cnt_q - 8'd1;
            rlast_q <= (r_cnt_q == 8'd1);
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign wlast_err     = wlast_err_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rdata   = rdata_q;
endmodule

// File: tb/tb_axi_mem_responder.sv
// Bench for axi_mem_responder: directed table, corner-case sequences and random
// bursts checked against a byte-level array model of the memory.
module tb_axi_mem_responder;
  localparam int AW = 64, DW = 512, BW = 64, D = 1024, TO = 3000;

  logic          ap_clk, ap_rst_n;
  logic          s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready, s_axi_wlast;
  logic [AW-1:0] s_axi_awaddr, s_axi_araddr;
  logic [7:0]    s_axi_awlen, s_axi_arlen;
  logic [DW-1:0] s_axi_wdata, s_axi_rdata;
  logic [BW-1:0] s_axi_wstrb;
  logic          s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic          s_axi_rvalid, s_axi_rready, s_axi_rlast, wlast_err;

  axi_mem_responder dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rlast(s_axi_rlast),
    .wlast_err(wlast_err)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [AW-1:0] waddr;
    logic [7:0]    wbyte;
    logic [BW-1:0] strb;
    logic [AW-1:0] raddr;
    logic [7:0]    exp0;
    logic [7:0]    exp63;
  } vec_t;

  int            tests = 0, fails = 0;
  logic [DW-1:0] mdl      [D];
  logic [DW-1:0] wbuf     [256];
  logic [BW-1:0] sbuf     [256];
  logic [DW-1:0] rd_words [256];
  int            rd_cycles;

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int j = 0; j < DW/32; j++) w[32*j +: 32] = $urandom;
    return w;
  endfunction

  function automatic int widx(input logic [AW-1:0] a);
    return int'((a / 64) % D);
  endfunction

  // All handshake tasks start and end on a falling edge.
  task automatic do_write(input logic [AW-1:0] addr, input int len, input int early, input bit gaps);
    int cyc = 0, beat = 0, ix;
    bit hs;
    ix = widx(addr);
    s_axi_awvalid = 1'b1; s_axi_awaddr = addr; s_axi_awlen = 8'(len);
    while (!s_axi_awready && cyc < TO) begin @(negedge ap_clk); cyc++; end
    @(negedge ap_clk);
    s_axi_awvalid = 1'b0;
    while (beat <= len && cyc < TO) begin
      s_axi_wvalid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      s_axi_wdata  = wbuf[beat];
      s_axi_wstrb  = sbuf[beat];
      s_axi_wlast  = (early >= 0) ? (beat == early) : (beat == len);
      hs = s_axi_wvalid && s_axi_wready;
      @(negedge ap_clk); cyc++;
      if (hs) begin
        for (int b = 0; b < BW; b++)
          if (sbuf[beat][b]) mdl[(ix + beat) % D][8*b +: 8] = wbuf[beat][8*b +: 8];
        beat++;
      end
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    chk("write_done", cyc < TO, 1);
  endtask

  task automatic do_bresp(input bit gaps);
    int cyc = 0;
    bit done = 0;
    while (!done && cyc < TO) begin
      s_axi_bready = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      done = s_axi_bvalid && s_axi_bready;
      @(negedge ap_clk); cyc++;
    end
    s_axi_bready = 1'b0;
    chk("bresp_done", done, 1);
    chk("bvalid_drop", s_axi_bvalid, 0);
    chk("awready_after_b", s_axi_awready, 1);
  endtask

  // mode: 0 rready high, 1 toggling (stall first), 2 random
  task automatic do_read(input logic [AW-1:0] addr, input int len, input int mode);
    int cyc = 0, beat = 0, k = 0, ix;
    bit hs, stall = 0;
    logic [DW-1:0] pd;
    logic pl;
    ix = widx(addr);
    s_axi_arvalid = 1'b1; s_axi_araddr = addr; s_axi_arlen = 8'(len);
    while (!s_axi_arready && cyc < TO) begin @(negedge ap_clk); cyc++; end
    @(negedge ap_clk);
    s_axi_arvalid = 1'b0;
    chk("ar_to_rvalid", s_axi_rvalid, 1);
    while (beat <= len && cyc < TO) begin
      case (mode)
        0:       s_axi_rready = 1'b1;
        1:       s_axi_rready = (k % 2) == 1;
        default: s_axi_rready = 1'($urandom_range(0, 1));
      endcase
      if (stall) begin
        chk("stall_rvalid", s_axi_rvalid, 1);
        chk("stall_rdata", s_axi_rdata, pd);
        chk("stall_rlast", s_axi_rlast, pl);
      end
      if (s_axi_rvalid) begin
        chk("rdata", s_axi_rdata, mdl[(ix + beat) % D]);
        chk("rlast", s_axi_rlast, beat == len);
      end
      hs = s_axi_rvalid && s_axi_rready;
      stall = s_axi_rvalid && !s_axi_rready;
      pd = s_axi_rdata; pl = s_axi_rlast;
      if (hs) rd_words[beat] = s_axi_rdata;
      @(negedge ap_clk); cyc++; k++;
      if (hs) beat++;
    end
    s_axi_rready = 1'b0;
    rd_cycles = k;
    chk("read_done", cyc < TO, 1);
    chk("rvalid_after_last", s_axi_rvalid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          vecs [7];
    logic [DW-1:0] p0, p1023;
    logic [AW-1:0] ra;
    int            cyc, rl;

    ap_rst_n = 1'b1;
    s_axi_awvalid = 0; s_axi_awaddr = '0; s_axi_awlen = '0;
    s_axi_wvalid = 0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 0;
    s_axi_bready = 0; s_axi_arvalid = 0; s_axi_araddr = '0; s_axi_arlen = '0;
    s_axi_rready = 0;
    #3 ap_rst_n = 1'b0;
    #1;
    chk("rst_awready", s_axi_awready, 1);
    chk("rst_arready", s_axi_arready, 1);
    chk("rst_wready", s_axi_wready, 0);
    chk("rst_bvalid", s_axi_bvalid, 0);
    chk("rst_rvalid", s_axi_rvalid, 0);
    chk("rst_rlast", s_axi_rlast, 0);
    chk("rst_rdata", s_axi_rdata, 0);
    chk("rst_wlast_err", wlast_err, 0);
    repeat (3) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);

    // Give every word a known value so the model never holds X.
    for (int blk = 0; blk < 4; blk++) begin
      for (int i = 0; i < 256; i++) begin wbuf[i] = rand_word(); sbuf[i] = '1; end
      do_write(64'(blk * 256 * 64), 255, -1, 0);
      do_bresp(0);
    end

    // Single write then read
    wbuf[0] = {64{8'hA5}}; sbuf[0] = '1;
    do_write(64'h0, 0, -1, 0);
    do_bresp(0);
    do_read(64'h0, 0, 0);
    chk("single_rdata", rd_words[0], {64{8'hA5}});

    // Table: address folding, offset ignore and strobe lanes
    vecs[0] = '{64'h40,  8'h11, 64'hFFFF_FFFF_FFFF_FFFF, 64'h40, 8'h11, 8'h11};
    vecs[1] = '{64'h7F,  8'h22, 64'h1,                   64'h40, 8'h22, 8'h11};
    vecs[2] = '{64'h40,  8'h33, 64'h8000_0000_0000_0000, 64'h41, 8'h22, 8'h33};
    vecs[3] = '{64'h10040, 8'h44, 64'hFFFF_FFFF_FFFF_FFFF, 64'h40, 8'h44, 8'h44};
    vecs[4] = '{64'h80,  8'h55, 64'hFFFF_FFFF_FFFF_FFFF, 64'h80, 8'h55, 8'h55};
    vecs[5] = '{64'h80,  8'h66, 64'h0,                   64'hBF, 8'h55, 8'h55};
    vecs[6] = '{64'hFFFF_FFFF_FFFF_FFC0, 8'h77, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFC0, 8'h77, 8'h77};
    for (int i = 0; i < 7; i++) begin
      wbuf[0] = {BW{vecs[i].wbyte}}; sbuf[0] = vecs[i].strb;
      do_write(vecs[i].waddr, 0, -1, 0);
      do_bresp(0);
      do_read(vecs[i].raddr, 0, 0);
      chk($sformatf("vec%0d_lane0", i), rd_words[0][7:0], vecs[i].exp0);
      chk($sformatf("vec%0d_lane63", i), rd_words[0][511:504], vecs[i].exp63);
    end

    // 16-beat burst, toggling rready on readback
    for (int i = 0; i < 16; i++) begin wbuf[i] = DW'(i); sbuf[i] = '1; end
    do_write(64'h1000, 15, -1, 1);
    do_bresp(1);
    do_read(64'h1000, 15, 1);
    for (int i = 0; i < 16; i++) chk($sformatf("burst_beat%0d", i), rd_words[i], DW'(i));

    // Strobes across the wrap from the last word to word 0
    p1023 = mdl[1023]; p0 = mdl[0];
    wbuf[0] = '1; wbuf[1] = '1; sbuf[0] = 64'hF; sbuf[1] = 64'hF;
    do_write(64'(1023 * 64), 1, -1, 0);
    do_bresp(0);
    do_read(64'(1023 * 64), 1, 2);
    chk("wrap_1023", rd_words[0], {p1023[511:32], 32'hFFFF_FFFF});
    chk("wrap_0", rd_words[1], {p0[511:32], 32'hFFFF_FFFF});

    // wlast early on a 4-beat burst
    chk("err_clear", wlast_err, 0);
    for (int i = 0; i < 4; i++) begin wbuf[i] = rand_word(); sbuf[i] = '1; end
    do_write(64'h2000, 3, 2, 0);
    chk("err_set", wlast_err, 1);
    chk("err_wready_off", s_axi_wready, 0);
    chk("err_bvalid", s_axi_bvalid, 1);
    do_bresp(0);
    for (int i = 0; i < 3; i++) begin
      @(negedge ap_clk);
      chk("err_single_b", s_axi_bvalid, 0);
    end
    do_read(64'h2000, 3, 0);

    // Concurrent 256-beat bursts on disjoint ranges
    for (int i = 0; i < 256; i++) begin wbuf[i] = rand_word(); sbuf[i] = '1; end
    fork
      do_write(64'h0, 255, -1, 0);
      do_read(64'(512 * 64), 255, 0);
    join
    chk("read_rate", rd_cycles, 256);
    do_bresp(0);

    // Async reset in the middle of an 8-beat read
    s_axi_arvalid = 1'b1; s_axi_araddr = 64'(300 * 64); s_axi_arlen = 8'd7;
    cyc = 0;
    while (!s_axi_arready && cyc < TO) begin @(negedge ap_clk); cyc++; end
    @(negedge ap_clk);
    s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
    repeat (3) @(negedge ap_clk);
    #2 ap_rst_n = 1'b0;
    #1;
    chk("midrst_rvalid", s_axi_rvalid, 0);
    chk("midrst_rlast", s_axi_rlast, 0);
    chk("midrst_rdata", s_axi_rdata, 0);
    chk("midrst_wlast_err", wlast_err, 0);
    @(negedge ap_clk);
    s_axi_rready = 1'b0; ap_rst_n = 1'b1;
    @(negedge ap_clk);
    chk("midrst_arready", s_axi_arready, 1);
    do_read(64'(300 * 64), 7, 2);

    // Random bursts with random handshakes
    for (int it = 0; it < 25; it++) begin
      ra = {$urandom, $urandom};
      rl = $urandom_range(0, 15);
      for (int i = 0; i <= rl; i++) begin wbuf[i] = rand_word(); sbuf[i] = {$urandom, $urandom}; end
      do_write(ra, rl, -1, 1);
      do_bresp(1);
      do_read(ra + 64'($urandom_range(0, 3) * 64), $urandom_range(0, 15), 2);
    end
    chk("random_no_err", wlast_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
